// File: rtl/reg_cmd_ctrl.sv
// Byte-stream command decoder driving a register file: 0xAA addr data writes,
// 0xBB addr reads and returns the register byte to the transmitter.
module reg_cmd_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  input  logic             TX_BUSY,
  output logic             CMD_ERR,
  output logic             BUSY
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] CMD_WR = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] CMD_RD = WIDTH'(8'hBB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ADDR-1:0]  r_addr, w_addr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_wren_nxt, w_rden_nxt, w_err_nxt, w_txvld_nxt;
  logic [ADDR-1:0]  w_address_nxt;
  logic [WIDTH-1:0] w_wrdata_nxt, w_txdata_nxt;

  // An address byte is legal only when every bit above the address field is zero.
  function automatic logic addr_ok(input logic [WIDTH-1:0] b);
    return (b >> ADDR) == '0;
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_wren_nxt    = 1'b0;
    w_rden_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_address_nxt = Address;
    w_wrdata_nxt  = WrData;
    w_txdata_nxt  = TX_P_DATA;
    w_txvld_nxt   = TX_D_VLD;
    case (r_state)
      IDLE: begin
        w_txvld_nxt = 1'b0;
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR)      w_state_nxt = WR_ADDR;
          else if (RX_P_DATA == CMD_RD) w_state_nxt = RD_ADDR;
          else                          w_err_nxt   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok(RX_P_DATA)) begin
            w_addr_nxt  = RX_P_DATA[ADDR-1:0];
            w_state_nxt = WR_DATA;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          w_wren_nxt    = 1'b1;
          w_address_nxt = r_addr;
          w_wrdata_nxt  = RX_P_DATA;
          w_state_nxt   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok(RX_P_DATA)) begin
            w_rden_nxt    = 1'b1;
            w_addr_nxt    = RX_P_DATA[ADDR-1:0];
            w_address_nxt = RX_P_DATA[ADDR-1:0];
            w_cnt_nxt     = '0;
            w_state_nxt   = RD_WAIT;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      RD_WAIT: begin
        // Stray bytes are dropped but flagged; the read keeps going.
        w_err_nxt = RX_D_VLD;
        if (RdData_VLD) begin
          w_txdata_nxt = RdData;
          w_txvld_nxt  = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = TX_SEND;
        end else if (r_cnt == CNT_LAST) begin
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      TX_SEND: begin
        w_err_nxt = RX_D_VLD;
        if (!TX_BUSY) begin
          w_txvld_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txvld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_cnt     <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      CMD_ERR   <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      WrEn      <= w_wren_nxt;
      RdEn      <= w_rden_nxt;
      CMD_ERR   <= w_err_nxt;
      Address   <= w_address_nxt;
      WrData    <= w_wrdata_nxt;
      TX_P_DATA <= w_txdata_nxt;
      TX_D_VLD  <= w_txvld_nxt;
      BUSY      <= (w_state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl: write, read, back-pressured read,
// malformed commands, read timeout and reset in the middle of a command.
module tb_reg_cmd_ctrl;
  localparam int WIDTH   = 8;
  localparam int ADDR    = 4;
  localparam int TIMEOUT = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] RX_P_DATA;
  logic             RX_D_VLD;
  logic             WrEn, RdEn;
  logic [ADDR-1:0]  Address;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] RdData;
  logic             RdData_VLD;
  logic [WIDTH-1:0] TX_P_DATA;
  logic             TX_D_VLD;
  logic             TX_BUSY;
  logic             CMD_ERR;
  logic             BUSY;

  int checks = 0;
  int errors = 0;

  reg_cmd_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_VLD(RdData_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  initial begin
    RST = 1'b1; RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1;
    RdData = '0; RdData_VLD = 1'b0; TX_BUSY = 1'b0;
    tick(); tick();
    chk("rst_wren", WrEn, 0);
    chk("rst_rden", RdEn, 0);
    chk("rst_txvld", TX_D_VLD, 0);
    chk("rst_err", CMD_ERR, 0);
    chk("rst_addr", Address, 0);
    chk("rst_wrdata", WrData, 0);
    chk("rst_txdata", TX_P_DATA, 0);
    chk("rst_busy", BUSY, 0);
    RX_D_VLD = 1'b0; RST = 1'b0;
    tick();
    chk("post_rst_busy", BUSY, 0);

    // Plain write AA 05 3C
    send(8'hAA);
    chk("wr_busy_cmd", BUSY, 1);
    send(8'h05);
    chk("wr_no_strobe_addr", WrEn, 0);
    send(8'h3C);
    chk("wr_wren", WrEn, 1);
    chk("wr_address", Address, 5);
    chk("wr_wrdata", WrData, 8'h3C);
    chk("wr_no_rden", RdEn, 0);
    chk("wr_no_err", CMD_ERR, 0);
    chk("wr_idle", BUSY, 0);
    tick();
    chk("wr_wren_one_cycle", WrEn, 0);
    chk("wr_address_hold", Address, 5);
    chk("wr_wrdata_hold", WrData, 8'h3C);

    // Read BB 02, data valid two cycles after RdEn
    RdData = 8'h1D;
    send(8'hBB);
    send(8'h02);
    chk("rd_rden", RdEn, 1);
    chk("rd_address", Address, 2);
    chk("rd_no_wren", WrEn, 0);
    tick();
    chk("rd_rden_one_cycle", RdEn, 0);
    chk("rd_wait_busy", BUSY, 1);
    tick();
    RdData_VLD = 1'b1;
    tick();
    RdData_VLD = 1'b0;
    chk("rd_txvld", TX_D_VLD, 1);
    chk("rd_txdata", TX_P_DATA, 8'h1D);
    tick();
    chk("rd_txvld_drop", TX_D_VLD, 0);
    chk("rd_idle", BUSY, 0);

    // Read with transmitter busy for five cycles, stray byte during TX_SEND
    TX_BUSY = 1'b1;
    RdData = 8'hA5;
    send(8'hBB);
    send(8'h06);
    chk("bp_rden", RdEn, 1);
    RdData_VLD = 1'b1;
    tick();
    RdData_VLD = 1'b0;
    RdData = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      chk("bp_txvld_held", TX_D_VLD, 1);
      chk("bp_txdata_stable", TX_P_DATA, 8'hA5);
      RX_P_DATA = 8'h77;
      RX_D_VLD  = (i == 2);
      tick();
      RX_D_VLD  = 1'b0;
      if (i == 2) chk("bp_stray_err", CMD_ERR, 1);
    end
    TX_BUSY = 1'b0;
    chk("bp_txvld_sixth", TX_D_VLD, 1);
    chk("bp_txdata_sixth", TX_P_DATA, 8'hA5);
    tick();
    chk("bp_txvld_drop", TX_D_VLD, 0);
    chk("bp_idle", BUSY, 0);

    // Bad command byte, bad address, then a good write
    send(8'h55);
    chk("bad_cmd_err", CMD_ERR, 1);
    chk("bad_cmd_busy", BUSY, 0);
    chk("bad_cmd_wren", WrEn, 0);
    chk("bad_cmd_rden", RdEn, 0);
    tick();
    chk("bad_cmd_err_pulse", CMD_ERR, 0);
    send(8'hAA);
    send(8'h1F);
    chk("bad_addr_err", CMD_ERR, 1);
    chk("bad_addr_idle", BUSY, 0);
    chk("bad_addr_wren", WrEn, 0);
    send(8'hAA);
    send(8'h01);
    send(8'h07);
    chk("rec_wren", WrEn, 1);
    chk("rec_address", Address, 1);
    chk("rec_wrdata", WrData, 8'h07);
    chk("rec_no_err", CMD_ERR, 0);

    // Read timeout
    send(8'hBB);
    send(8'h03);
    chk("to_rden", RdEn, 1);
    chk("to_address", Address, 3);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      chk("to_no_err_early", CMD_ERR, 0);
      chk("to_busy_wait", BUSY, 1);
    end
    tick();
    chk("to_err", CMD_ERR, 1);
    chk("to_idle", BUSY, 0);
    tick();
    chk("to_err_pulse", CMD_ERR, 0);

    // Reset in the middle of a write, data byte offered during reset
    send(8'hAA);
    send(8'h04);
    RST = 1'b1; RX_P_DATA = 8'h3C; RX_D_VLD = 1'b1;
    tick();
    RX_D_VLD = 1'b0; RST = 1'b0;
    chk("mrst_wren", WrEn, 0);
    chk("mrst_address", Address, 0);
    chk("mrst_wrdata", WrData, 0);
    chk("mrst_txdata", TX_P_DATA, 0);
    chk("mrst_busy", BUSY, 0);
    tick();
    chk("mrst_no_late_wren", WrEn, 0);
    send(8'hAA);
    send(8'h09);
    send(8'hE1);
    chk("mrst_wr_wren", WrEn, 1);
    chk("mrst_wr_address", Address, 9);
    chk("mrst_wr_wrdata", WrData, 8'hE1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
